viterbi_block_sequencer: RTL and testbench

- Sequences the combinational 8-metric Viterbi decision core (six-bit saturating path-metric adders, comparators, 4-bit decision m).
- Accepts a serial stream of 6-bit branch metrics and assembles blocks of eight into registers r0..r7 that drive the core.
- Waits a programmable settle time, captures the core's 4-bit decision, and presents it on a valid/ready output.
- Sits between the demodulator metric stream and the traceback/output logic.

---
 rtl/viterbi_block_sequencer.sv | 132 +++++++++++++
 tb/tb_viterbi_block_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_block_sequencer.sv
// Assembles eight serial branch metrics into r0..r7 for the Viterbi decision core and hands off its decision.
// Latency: decision is valid SETTLE edges after the eighth metric is accepted.
// Backpressure: in_ready drops from block completion until the decision is taken; out_valid holds until out_ready.
module viterbi_block_sequencer #(
    parameter int W      = 6,
    parameter int SETTLE = 3,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W-1:0]       in_metric,
    input  logic               in_sof,
    output logic [8*W-1:0]     core_r,
    input  logic [3:0]         core_m,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_m,
    output logic               busy,
    output logic               sync_err,
    output logic [CNT_W-1:0]   blk_cnt
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    // Settle counter reload: it counts down to zero, so SETTLE cycles means SETTLE-1.
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    state_t             state_q, state_d;
    logic [2:0]         idx_q, idx_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [8*W-1:0]     core_r_q, core_r_d;
    logic [3:0]         out_m_q, out_m_d;
    logic               out_valid_q, out_valid_d;
    logic               sync_err_q, sync_err_d;
    logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
    logic               accept;

    assign accept    = in_valid && (state_q == ST_LOAD);
    assign in_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_HOLD);
    assign core_r    = core_r_q;
    assign out_valid = out_valid_q;
    assign out_m     = out_m_q;
    assign sync_err  = sync_err_q;
    assign blk_cnt   = blk_cnt_q;

    // Next-state and datapath updates for the load / settle / hold sequence.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        core_r_d    = core_r_q;
        out_m_d     = out_m_q;
        out_valid_d = out_valid_q;
        sync_err_d  = sync_err_q;
        blk_cnt_d   = blk_cnt_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (in_sof) begin
                        // Start-of-block always realigns to r0; a partial block is
                        // abandoned in place and flagged.
                        core_r_d[W-1:0] = in_metric;
                        idx_d           = 3'd1;
                        if (idx_q != 3'd0) begin
                            sync_err_d = 1'b1;
                        end
                    end else begin
                        core_r_d[int'(idx_q)*W +: W] = in_metric;
                        if (idx_q == 3'd7) begin
                            idx_d   = 3'd0;
                            cnt_d   = SETTLE_LD;
                            state_d = ST_SETTLE;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    out_m_d     = core_m;
                    out_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    blk_cnt_d   = blk_cnt_q + CNT_W'(1);
                    state_d     = ST_LOAD;
                end
            end
            default: begin
                state_d     = ST_LOAD;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial block or pending decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            idx_q       <= 3'd0;
            cnt_q       <= 4'd0;
            core_r_q    <= '0;
            out_m_q     <= 4'd0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
            blk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            core_r_q    <= core_r_d;
            out_m_q     <= out_m_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
            blk_cnt_q   <= blk_cnt_d;
        end
    end

endmodule

// File: tb/tb_viterbi_block_sequencer.sv
// Bench for viterbi_block_sequencer: directed and randomized blocks against a metric-array model.
// Latency checked edge-by-edge from the eighth accept through the handshake.
// Backpressure exercised with random out_ready hold times and in_valid held while in_ready is low.
module tb_viterbi_block_sequencer;

    localparam int W      = 6;
    localparam int SETTLE = 3;
    localparam int CNT_W  = 16;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [W-1:0]       in_metric;
    logic               in_sof;
    logic [8*W-1:0]     core_r;
    logic [3:0]         core_m;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_m;
    logic               busy;
    logic               sync_err;
    logic [CNT_W-1:0]   blk_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: the eight metric slots, write position, sticky error, block count.
    logic [W-1:0]       mdl_r [8];
    int                 mdl_idx;
    bit                 mdl_err;
    logic [CNT_W-1:0]   mdl_blk;

    viterbi_block_sequencer #(.W(W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_metric (in_metric),
        .in_sof    (in_sof),
        .core_r    (core_r),
        .core_m    (core_m),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_m     (out_m),
        .busy      (busy),
        .sync_err  (sync_err),
        .blk_cnt   (blk_cnt)
    );

    // Core stub: decision is r0[3:0] xor r7[3:0].
    assign core_m = core_r[3:0] ^ core_r[7*W+3 -: 4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mdl_pack();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[i*W +: W] = mdl_r[i];
        return v;
    endfunction

    function automatic logic [63:0] mdl_dec();
        logic [63:0] v;
        v = '0;
        v[3:0] = mdl_r[0][3:0] ^ mdl_r[7][3:0];
        return v;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 8; i++) mdl_r[i] = '0;
        mdl_idx = 0;
        mdl_err = 0;
        mdl_blk = '0;
    endtask

    // Present one metric after 'gap' idle cycles; returns #1 after the accepting edge.
    task automatic push(input logic [W-1:0] m, input logic sof, input int gap);
        int n;
        for (int g = 0; g < gap; g++) @(negedge clk);
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        in_metric = m;
        in_sof    = sof;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_metric = W'($urandom);
        in_sof    = 1'($urandom);
        if (sof) begin
            if (mdl_idx != 0) mdl_err = 1;
            mdl_r[0] = m;
            mdl_idx  = 1;
        end else begin
            mdl_r[mdl_idx] = m;
            mdl_idx = (mdl_idx == 7) ? 0 : mdl_idx + 1;
        end
    endtask

    // Called right after the eighth accept: checks settle timing, hold stability, handshake.
    task automatic finish_block(input int hold, input bit preload);
        logic [63:0] exp_r;
        logic [63:0] exp_m;
        exp_r = mdl_pack();
        exp_m = mdl_dec();
        chk("core_r_loaded", {16'd0, core_r}, exp_r);
        for (int i = 1; i <= SETTLE; i++) begin
            @(negedge clk);
            chk("settle_out_valid", {63'd0, out_valid}, 64'd0);
            chk("settle_in_ready", {63'd0, in_ready}, 64'd0);
            chk("settle_busy", {63'd0, busy}, 64'd1);
            // Offer junk metrics while not ready; none may be taken.
            in_valid  = 1'($urandom);
            in_metric = W'($urandom);
            in_sof    = 1'($urandom);
        end
        @(negedge clk);
        chk("dec_out_valid", {63'd0, out_valid}, 64'd1);
        chk("dec_out_m", {60'd0, out_m}, exp_m);
        chk("dec_in_ready", {63'd0, in_ready}, 64'd0);
        chk("dec_sync_err", {63'd0, sync_err}, {63'd0, mdl_err});
        if (preload) begin
            force dut.blk_cnt_q = {CNT_W{1'b1}};
            @(negedge clk);
            release dut.blk_cnt_q;
            mdl_blk = {CNT_W{1'b1}};
            chk("preload_blk_cnt", {48'd0, blk_cnt}, {48'd0, mdl_blk});
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            @(negedge clk);
            chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
            chk("hold_out_m", {60'd0, out_m}, exp_m);
            chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
            chk("hold_core_r", {16'd0, core_r}, exp_r);
            chk("hold_blk_cnt", {48'd0, blk_cnt}, {48'd0, mdl_blk});
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        mdl_blk   = mdl_blk + 1'b1;
        chk("hs_out_valid", {63'd0, out_valid}, 64'd0);
        chk("hs_in_ready", {63'd0, in_ready}, 64'd1);
        chk("hs_busy", {63'd0, busy}, 64'd0);
        chk("hs_blk_cnt", {48'd0, blk_cnt}, {48'd0, mdl_blk});
        chk("hs_core_r", {16'd0, core_r}, exp_r);
    endtask

    task automatic send_block(input logic [W-1:0] a0, a1, a2, a3, a4, a5, a6, a7, input int gap);
        logic [W-1:0] v [8];
        v = '{a0, a1, a2, a3, a4, a5, a6, a7};
        for (int i = 0; i < 8; i++) push(v[i], (i == 0), gap);
    endtask

    initial begin
        bit partial;
        int k;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_metric = '0;
        in_sof    = 1'b0;
        out_ready = 1'b0;
        mdl_reset();

        // Reset state.
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_core_r", {16'd0, core_r}, 64'd0);
        chk("rst_out_m", {60'd0, out_m}, 64'd0);
        chk("rst_blk_cnt", {48'd0, blk_cnt}, 64'd0);
        chk("rst_sync_err", {63'd0, sync_err}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

        // Basic block, out_ready effectively high: 5 ^ 12 = 9.
        send_block(6'd5, 6'd1, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd12, 0);
        chk("blk1_model_dec", mdl_dec(), 64'd9);
        finish_block(0, 0);

        // Same block with 10 cycles of backpressure.
        send_block(6'd5, 6'd1, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'd12, 0);
        finish_block(10, 0);

        // Early start-of-block: sync_err, decision uses r0=2, r7=15.
        push(6'd9, 1'b1, 0);
        push(6'd10, 1'b0, 0);
        push(6'd11, 1'b0, 0);
        push(6'd2, 1'b1, 0);
        chk("sof_sync_err", {63'd0, sync_err}, 64'd1);
        push(6'd20, 1'b0, 0);
        push(6'd21, 1'b0, 0);
        push(6'd22, 1'b0, 0);
        push(6'd23, 1'b0, 0);
        push(6'd24, 1'b0, 0);
        push(6'd25, 1'b0, 0);
        push(6'd15, 1'b0, 0);
        chk("sof_model_dec", mdl_dec(), 64'd13);
        finish_block(2, 0);

        // in_valid toggling every cycle.
        send_block(6'd33, 6'd63, 6'd0, 6'd17, 6'd40, 6'd8, 6'd31, 6'd44, 1);
        finish_block(1, 0);

        // Reset during SETTLE aborts the decision.
        send_block(6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_core_r", {16'd0, core_r}, 64'd0);
        chk("midrst_blk_cnt", {48'd0, blk_cnt}, 64'd0);
        chk("midrst_sync_err", {63'd0, sync_err}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_out_valid", {63'd0, out_valid}, 64'd0);
        end
        send_block(6'd50, 6'd3, 6'd9, 6'd27, 6'd60, 6'd14, 6'd5, 6'd37, 0);
        finish_block(0, 0);

        // Randomized blocks, occasionally broken by an early start-of-block.
        for (int b = 0; b < 20; b++) begin
            partial = ($urandom_range(0, 3) == 0);
            if (partial) begin
                k = $urandom_range(1, 6);
                for (int i = 0; i < k; i++) push(W'($urandom), (i == 0), $urandom_range(0, 2));
            end
            for (int i = 0; i < 8; i++) begin
                push(W'($urandom), (i == 0) ? (partial ? 1'b1 : 1'($urandom)) : 1'b0,
                     $urandom_range(0, 2));
            end
            finish_block($urandom_range(0, 3), 0);
        end

        // Counter wrap from all-ones.
        send_block(6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd7, 6'd1, 0);
        finish_block(0, 1);
        chk("wrap_blk_cnt", {48'd0, blk_cnt}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
